// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer.
//  state_t : sequencer state encoding
//  PC_*    : pc_sel codes driven to the fetch stage
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_EXC = 2'b10;

endpackage

// File: rtl/md_timer.sv
// Fixed-latency mult/div timer: loadable down-counter.
//  clk   : core clock
//  _rst  : synchronous active-low reset
//  go    : load LAT-1 (start of a mult/div operation)
//  abort : clear the counter
//  zero  : counter is at zero
module md_timer #(
  parameter int unsigned LAT = 32
) (
  input  logic clk,
  input  logic _rst,
  input  logic go,
  input  logic abort,
  output logic zero
);

  localparam logic [7:0] LOAD = 8'(LAT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!_rst) begin
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (go) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage core.
// Merges load-use stall, mult/div occupancy, data-memory wait, branch and
// exception redirects into stage enables, bubble inserts and pc_sel.
//  clk, _rst                        : clock, synchronous active-low reset
//  _stall_en                        : load-use hazard (0 = stall)
//  exe_md, mem_req, mem_ready       : mult/div in EXE, memory access / completion
//  br_taken, exc_req                : branch redirect, exception redirect
//  if_en..wb_en                     : pipeline register load enables
//  bub_ifid, bub_idexe, bub_exemem  : NOP inserts
//  pc_sel                           : PC_SEQ / PC_BR / PC_EXC
//  md_go, md_abort, md_busy         : mult/div unit control and status
//  stall_cnt                        : saturating count of cycles with if_en==0
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             _stall_en,
  input  logic             exe_md,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             br_taken,
  input  logic             exc_req,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             bub_ifid,
  output logic             bub_idexe,
  output logic             bub_exemem,
  output logic [1:0]       pc_sel,
  output logic             md_go,
  output logic             md_abort,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t state;
  state_t state_nxt;
  logic   md_zero;
  logic   mem_stall;

  assign mem_stall = mem_req && !mem_ready;

  md_timer #(.LAT(MD_LAT)) u_md_timer (
    .clk   (clk),
    ._rst  (_rst),
    .go    (md_go),
    .abort (md_abort),
    .zero  (md_zero)
  );

  always_comb begin
    if_en      = 1'b1;
    id_en      = 1'b1;
    exe_en     = 1'b1;
    mem_en     = 1'b1;
    wb_en      = 1'b1;
    bub_ifid   = 1'b0;
    bub_idexe  = 1'b0;
    bub_exemem = 1'b0;
    pc_sel     = PC_SEQ;
    md_go      = 1'b0;
    md_abort   = 1'b0;
    md_busy    = 1'b0;
    state_nxt  = state;

    if (!_rst) begin
      {if_en, id_en, exe_en, mem_en, wb_en} = '0;
      {bub_ifid, bub_idexe, bub_exemem}     = '1;
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (exc_req) begin
            pc_sel = PC_EXC;
            {bub_ifid, bub_idexe, bub_exemem} = '1;
          end else if (mem_stall) begin
            {if_en, id_en, exe_en, mem_en, wb_en} = '0;
            state_nxt = MEM_WAIT;
          end else if (exe_md) begin
            md_go      = 1'b1;
            if_en      = 1'b0;
            id_en      = 1'b0;
            exe_en     = 1'b0;
            bub_exemem = 1'b1;
            state_nxt  = MD_WAIT;
          end else if (!_stall_en) begin
            if_en     = 1'b0;
            id_en     = 1'b0;
            bub_idexe = 1'b1;
          end else if (br_taken) begin
            pc_sel = PC_BR;
          end
        end
        MEM_WAIT: begin
          // Exceptions are held by MEM until the access completes.
          {if_en, id_en, exe_en, mem_en, wb_en} = '0;
          if (mem_ready) state_nxt = RUN;
        end
        MD_WAIT: begin
          md_busy = 1'b1;
          if (exc_req) begin
            md_abort = 1'b1;
            pc_sel   = PC_EXC;
            {bub_ifid, bub_idexe, bub_exemem} = '1;
            state_nxt = RUN;
          end else begin
            if_en      = 1'b0;
            id_en      = 1'b0;
            exe_en     = 1'b0;
            bub_exemem = 1'b1;
            // A memory wait overlaps the mult/div; it only takes over
            // the FSM once the timer has expired.
            if (mem_stall) begin
              mem_en = 1'b0;
              wb_en  = 1'b0;
            end
            if (md_zero) state_nxt = mem_stall ? MEM_WAIT : RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!_rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!_rst) begin
      stall_cnt <= '0;
    end else if (!if_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (MD_LAT=4, CNT_W=4): directed sequences
// followed by biased random stimulus, checked against a behavioural model.
module tb_pipe_ctrl;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic _rst = 1'b0;
  logic _stall_en = 1'b1;
  logic exe_md = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic br_taken = 1'b0, exc_req = 1'b0;
  logic if_en, id_en, exe_en, mem_en, wb_en;
  logic bub_ifid, bub_idexe, bub_exemem;
  logic [1:0] pc_sel;
  logic md_go, md_abort, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  pipe_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), ._rst(_rst), ._stall_en(_stall_en), .exe_md(exe_md),
    .mem_req(mem_req), .mem_ready(mem_ready), .br_taken(br_taken),
    .exc_req(exc_req), .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
    .mem_en(mem_en), .wb_en(wb_en), .bub_ifid(bub_ifid),
    .bub_idexe(bub_idexe), .bub_exemem(bub_exemem), .pc_sel(pc_sel),
    .md_go(md_go), .md_abort(md_abort), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] en;   // if,id,exe,mem,wb
    logic [2:0] bub;  // ifid,idexe,exemem
    logic [1:0] pc;
    logic       go;
    logic       abort;
    logic       busy;
    logic [3:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: remaining mult/div cycles, pending memory wait,
  // and the stall counter value as an integer.
  int md_left  = 0;
  bit mem_wait = 0;
  int stalls   = 0;

  task automatic step(input bit r, input bit se, input bit md, input bit mq,
                      input bit mr, input bit br, input bit ex);
    obs_t e;
    bit   ms;
    @(negedge clk);
    _rst = r; _stall_en = se; exe_md = md; mem_req = mq;
    mem_ready = mr; br_taken = br; exc_req = ex;
    ms = mq && !mr;
    e = '0;
    e.en  = 5'b11111;
    e.cnt = 4'(stalls);
    if (!r) begin
      e.en = 5'b00000; e.bub = 3'b111;
      md_left = 0; mem_wait = 0; stalls = 0;
    end else begin
      if (mem_wait) begin
        e.en = 5'b00000;
        if (mr) mem_wait = 0;
      end else if (md_left > 0) begin
        e.busy = 1;
        if (ex) begin
          e.abort = 1; e.pc = 2'b10; e.bub = 3'b111; md_left = 0;
        end else begin
          e.en  = ms ? 5'b00000 : 5'b00011;
          e.bub = 3'b001;
          if (md_left == 1) begin
            md_left = 0; mem_wait = ms;
          end else begin
            md_left = md_left - 1;
          end
        end
      end else if (ex) begin
        e.pc = 2'b10; e.bub = 3'b111;
      end else if (ms) begin
        e.en = 5'b00000; mem_wait = 1;
      end else if (md) begin
        e.go = 1; e.en = 5'b00011; e.bub = 3'b001; md_left = MD_LAT;
      end else if (!se) begin
        e.en = 5'b00111; e.bub = 3'b010;
      end else if (br) begin
        e.pc = 2'b01;
      end
      if (!e.en[4] && stalls < CNT_MAX) stalls = stalls + 1;
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    obs_t a, e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{en: {if_en, id_en, exe_en, mem_en, wb_en},
              bub: {bub_ifid, bub_idexe, bub_exemem}, pc: pc_sel,
              go: md_go, abort: md_abort, busy: md_busy, cnt: stall_cnt};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL cyc%0d outputs: got en=%b bub=%b pc=%b go=%b ab=%b busy=%b cnt=%0d, want en=%b bub=%b pc=%b go=%b ab=%b busy=%b cnt=%0d",
                   cyc, a.en, a.bub, a.pc, a.go, a.abort, a.busy, a.cnt,
                   e.en, e.bub, e.pc, e.go, e.abort, e.busy, e.cnt);
        end
        cyc++;
      end
    end
  end

  initial begin : driver
    // T1 reset then release
    step(0,1,0,0,0,0,0); step(0,1,0,0,0,0,0);
    step(1,1,0,0,0,0,0); step(1,1,0,0,0,0,0);
    // T2 load-use
    step(1,0,0,0,0,0,0); step(1,1,0,0,0,0,0);
    // branch
    step(1,1,0,0,0,1,0); step(1,1,0,0,0,0,0);
    // T3 mult/div full latency, exe_md held while in EXE
    step(1,1,1,0,0,0,0);
    for (int i = 0; i < MD_LAT; i++) step(1,1,1,0,0,0,0);
    step(1,1,0,0,0,0,0);
    // T4 exception on 2nd MD_WAIT cycle
    step(1,1,1,0,0,0,0); step(1,1,1,0,0,0,0); step(1,1,1,0,0,0,1);
    step(1,1,0,0,0,0,0);
    // T5 mem wait with exception raised mid-wait and held
    step(1,1,0,1,0,0,0); step(1,1,0,1,0,0,1); step(1,1,0,1,0,0,1);
    step(1,1,0,1,1,0,1); step(1,1,0,0,0,0,1); step(1,1,0,0,0,0,0);
    // mult/div expiring into a persisting memory wait
    step(1,1,1,0,0,0,0);
    for (int i = 0; i < MD_LAT; i++) step(1,1,1,1,0,0,0);
    step(1,1,0,1,0,0,0); step(1,1,0,1,1,0,0); step(1,1,0,0,0,0,0);
    // T6 saturation
    for (int i = 0; i < 20; i++) step(1,0,0,0,0,0,0);
    step(1,1,0,0,0,0,0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit mq;
      mq = ($urandom_range(3) == 0);
      step($urandom_range(149) != 0, $urandom_range(7) != 0,
           $urandom_range(7) == 0, mq, $urandom_range(1) == 1,
           $urandom_range(5) == 0, $urandom_range(15) == 0);
    end
    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
